tnn_seq_classifier: RTL and testbench
=====================================

TNN_SEQ_CLASSIFIER -- requirements
Module: tnn_seq_classifier

Interface
REQ-001 SHALL have parameter N, default 11: number of input features.
REQ-002 SHALL have parameter B, default 4: bits per feature, unsigned.
REQ-003 SHALL have parameter M, default 40: number of hidden neurons.
REQ-004 SHALL have parameter C, default 6: number of output classes; C >= 2.
REQ-005 SHALL have parameter P, default 8: hidden neurons evaluated per cycle; 1 <= P <= M.
REQ-006 SHALL have parameter W1, width 2*N*M, default 0: hidden ternary weights; the weight for neuron j, feature i is at [2*(j*N+i)+:2].
REQ-007 SHALL have parameter W2, width 2*C*M, default 0: output ternary weights; the weight for class k, hidden j is at [2*(k*M+j)+:2].
REQ-008 SHALL decode ternary weight codes as 2'b01=+1, 2'b11=-1, 2'b00=0 and 2'b10=0.
REQ-009 SHALL have one clock and an asynchronous active-low reset.
REQ-010 clk  input  1  rising-edge clock.
REQ-011 rst_n  input  1  asynchronous active-low reset.
REQ-012 in_valid  input  1  inp is valid.
REQ-013 in_ready  output  1  block accepts inp.
REQ-014 inp  input  N*B  features; feature i is at [i*B+:B].
REQ-015 out_valid  output  1  klass and mid are valid.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 klass  output  $clog2(C)  winning class index.
REQ-018 mid  output  M  hidden-layer bit vector; bit j is neuron j.

Function
REQ-019 SHALL use an FSM with four states: IDLE, HID, OUT and DONE.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 out_valid SHALL be 1 only in DONE.
REQ-022 An input handshake is in_valid && in_ready at a rising edge (cycle T); at that edge the block SHALL capture inp internally and move to HID.
REQ-023 HID SHALL last H = ceil(M/P) cycles; in pass h it SHALL compute neurons h*P .. min(h*P+P, M)-1.
REQ-024 In HID, acc_j SHALL be the sum over i of w1(j,i)*x_i, signed, with width clog2(N*(2^B-1)+1)+1; mid[j] SHALL be 1 iff acc_j >= 0.
REQ-025 OUT SHALL last C cycles, evaluating class k in cycle k.
REQ-026 In OUT, score_k SHALL be the sum over j of w2(k,j)*(mid[j] ? +1 : -1), signed, with width clog2(M+1)+1.
REQ-027 In OUT, the block SHALL keep a running best score and index; a candidate SHALL replace the best only if its score is strictly greater, so ties resolve to the lowest index.
REQ-028 After OUT, the block SHALL enter DONE and register klass; out_valid SHALL first be 1 in cycle T+H+C+1 (latency L = H+C+1).
REQ-029 In DONE, klass and mid SHALL hold stable until out_ready=1; out_valid && out_ready SHALL move the FSM to IDLE on the next edge.
REQ-030 In IDLE, klass and mid SHALL keep their last values.
REQ-031 in_valid SHALL be ignored outside IDLE, and changes to inp after capture SHALL have no effect.
REQ-032 A new input SHALL NOT be accepted in the same cycle as the output handshake; the earliest next acceptance is one cycle later.

Reset
REQ-033 While rst_n=0, the block SHALL be in IDLE with in_ready=1, out_valid=0, klass=0, mid=0, and all accumulators, pass counters and best score/index cleared.
REQ-034 Asserting rst_n mid-operation (HID, OUT or DONE) SHALL abort the transaction immediately, with no output handshake.
REQ-035 After rst_n deasserts, the first rising edge SHALL be able to accept an input.

Verification
REQ-036 Reset: hold rst_n=0, drive in_valid=1 -> in_ready=1, out_valid=0, klass=0, mid=0, and no capture occurs.
REQ-037 Defaults, W1=W2=0, inp=44'h46012229a22 accepted at T -> out_valid rises at T+12, mid=40'hFFFFFFFFFF, all scores 0, klass=0.
REQ-038 W1 all +1, W2 class 3 all +1 and other classes all -1, any inp -> mid all ones, score3=40, others -40, klass=3.
REQ-039 Tie and partial pass: P=16 (H=3, L=10), W2 classes 2 and 4 identical and maximal -> klass=2, with out_valid at T+10.
REQ-040 Backpressure: out_ready=0 for 20 cycles with in_valid=1 -> out_valid, klass and mid stay stable, in_ready=0, and no capture; out_ready=1 -> IDLE next cycle.
REQ-041 Reset mid-HID at T+3 -> outputs return to reset values; the next transaction gives the same result as a run with no reset.

Source files
------------

// File: rtl/tnn_seq_classifier.sv
// tnn_seq_classifier: two-layer ternary network, P hidden neurons per cycle,
// then one output class per cycle with a running argmax.
module tnn_seq_classifier #(
  parameter int N = 11,
  parameter int B = 4,
  parameter int M = 40,
  parameter int C = 6,
  parameter int P = 8,
  parameter logic [2*N*M-1:0] W1 = '0,
  parameter logic [2*C*M-1:0] W2 = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*B-1:0]       inp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(C)-1:0] klass,
  output logic [M-1:0]         mid
);
  localparam int H  = (M + P - 1) / P;
  localparam int HW = H > 1 ? $clog2(H) : 1;
  localparam int KW = $clog2(C);
  localparam int AW = $clog2(N * (2**B - 1) + 1) + 1;
  localparam int SW = $clog2(M + 1) + 1;
  localparam logic [1:0] IDLE = 2'd0, HID = 2'd1, OUT = 2'd2, DONE = 2'd3;
  logic [1:0]           state_q, state_d;
  logic [N*B-1:0]       x_q, x_d;
  logic [HW-1:0]        h_q, h_d;
  logic [KW-1:0]        k_q, k_d, best_idx_q, best_idx_d, klass_q, klass_d;
  logic [M-1:0]         mid_q, mid_d;
  logic signed [SW-1:0] best_q, best_d, score;
  logic signed [AW-1:0] acc;
  int                   j;
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    h_d        = h_q;
    k_d        = k_q;
    mid_d      = mid_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    klass_d    = klass_q;
    acc        = '0;
    score      = '0;
    j          = 0;
    // lane p of pass h handles neuron h*P+p; the last pass may be partial
    for (int p = 0; p < P; p++) begin
      j   = int'(h_q) * P + p;
      acc = '0;
      if (j < M) begin
        for (int i = 0; i < N; i++)
          acc = W1[2*(j*N+i)+:2] == 2'b01 ? acc + AW'(x_q[i*B+:B]) :
                W1[2*(j*N+i)+:2] == 2'b11 ? acc - AW'(x_q[i*B+:B]) : acc;
        if (state_q == HID) mid_d[j] = ~acc[AW-1];
      end
    end
    // nonzero weight iff bit 0 set; product is +1 when sign bit differs from mid
    for (int n = 0; n < M; n++)
      score = !W2[2*(int'(k_q)*M+n)] ? score :
              (W2[2*(int'(k_q)*M+n)+1] ^ mid_q[n]) ? score + SW'(1) : score - SW'(1);
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = HID;
        x_d     = inp;
        h_d     = '0;
      end
      HID: begin
        h_d = h_q + 1'b1;
        if (h_q == HW'(H - 1)) begin
          state_d = OUT;
          h_d     = '0;
          k_d     = '0;
        end
      end
      OUT: begin
        if (k_q == '0 || score > best_q) begin
          best_d     = score;
          best_idx_d = k_q;
        end
        k_d = k_q + 1'b1;
        if (k_q == KW'(C - 1)) begin
          state_d = DONE;
          k_d     = '0;
          klass_d = best_idx_d;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      h_q        <= '0;
      k_q        <= '0;
      mid_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      klass_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      h_q        <= h_d;
      k_q        <= k_d;
      mid_q      <= mid_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      klass_q    <= klass_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign klass     = klass_q;
  assign mid       = mid_q;
endmodule

// File: tb/tb_tnn_seq_classifier.sv
// tb_tnn_seq_classifier: four differently-weighted instances driven with random
// traffic, each checked by a queue scoreboard against an arithmetic model.
module tb_tnn_seq_classifier;
  localparam int NT = 25, LIMIT = 20000;
  typedef struct {int t; logic [42:0] r;} exp_t;
  logic clk = 0, rst_n = 0;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: all-zero weights; 1: random; 2: W1 all +1, class 3 wins; 3: W1 all +1, classes 2/4 tie at max
  function automatic logic [879:0] w1_of(int g);
    logic [879:0] w;
    int unsigned s;
    s = 32'h1234_5678 + g;
    for (int i = 0; i < 440; i++) begin
      s = s * 1103515245 + 12345;
      w[2*i+:2] = g == 0 ? 2'b00 : g >= 2 ? 2'b01 : 2'(s >> 16);
    end
    return w;
  endfunction

  function automatic logic [479:0] w2_of(int g);
    logic [479:0] w;
    int unsigned s;
    int k;
    s = 32'h9e37_79b9 + g;
    for (int i = 0; i < 240; i++) begin
      s = s * 1103515245 + 12345;
      k = i / 40;
      w[2*i+:2] = g == 0 ? 2'b00 : g == 1 ? 2'(s >> 16) :
                  g == 2 ? (k == 3 ? 2'b01 : 2'b11) :
                  (k == 2 || k == 4) ? 2'b01 : 2'(s >> 16);
    end
    return w;
  endfunction

  function automatic int wv(logic [1:0] c);
    return c == 2'b01 ? 1 : c == 2'b11 ? -1 : 0;
  endfunction

  function automatic logic [42:0] model(int g, logic [43:0] x);
    logic [879:0] w1;
    logic [479:0] w2;
    logic [39:0] m;
    int a, s, bs, best;
    w1 = w1_of(g);
    w2 = w2_of(g);
    bs = 0;
    best = 0;
    for (int n = 0; n < 40; n++) begin
      a = 0;
      for (int i = 0; i < 11; i++) a += wv(w1[2*(n*11+i)+:2]) * int'(x[i*4+:4]);
      m[n] = a >= 0;
    end
    for (int k = 0; k < 6; k++) begin
      s = 0;
      for (int n = 0; n < 40; n++) s += wv(w2[2*(k*40+n)+:2]) * (m[n] ? 1 : -1);
      if (k == 0 || s > bs) begin
        bs = s;
        best = k;
      end
    end
    return {3'(best), m};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int PP = g == 1 ? 7 : g == 3 ? 16 : 8;
    localparam int L  = (40 + PP - 1) / PP + 7;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [43:0] inp;
    logic [2:0] klass;
    logic [39:0] mid;
    exp_t q[$];
    int ntx = 0, last_t = 0;
    bit fin = 0, seen = 0, idle_next = 0;

    tnn_seq_classifier #(.P(PP), .W1(w1_of(g)), .W2(w2_of(g))) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
      .out_valid(out_valid), .out_ready(out_ready), .klass(klass), .mid(mid));

    initial begin
      int stall;
      stall = 20;
      out_ready = 0;
      forever begin
        @(negedge clk);
        if (stall > 0) begin
          out_ready = 0;
          stall--;
        end else if ($urandom_range(0, 9) == 0) begin
          out_ready = 0;
          stall = 20;
        end else out_ready = $urandom_range(0, 1) == 1;
      end
    end

    initial begin
      logic [43:0] last_inp, rep_inp, x;
      bit replay;
      exp_t e;
      in_valid = 0;
      inp = '0;
      last_inp = g == 0 ? 44'h46012229a22 : 44'({$urandom, $urandom});
      rep_inp = last_inp;
      replay = 1;
      while (ntx < NT) begin
        @(negedge clk);
        if (!rst_n) begin
          in_valid = 1;
          inp = 44'({$urandom, $urandom});
          replay = 1;
          rep_inp = last_inp;
        end else begin
          x = replay ? rep_inp : 44'({$urandom, $urandom});
          in_valid = $urandom_range(0, 1) == 1;
          inp = x;
          if (in_valid && in_ready) begin
            e.t = cyc;
            e.r = model(g, x);
            q.push_back(e);
            replay = 0;
            last_inp = x;
            last_t = cyc;
            ntx++;
          end
        end
      end
      @(negedge clk);
      in_valid = 0;
      while (q.size() > 0) @(negedge clk);
      fin = 1;
    end

    always @(negedge clk) begin
      #1;
      if (!rst_n) begin
        chk($sformatf("u%0d.reset", g), 64'({in_ready, out_valid, klass, mid}), 64'({1'b1, 44'd0}));
        q.delete();
        seen = 0;
        idle_next = 0;
      end else begin
        if (idle_next) chk($sformatf("u%0d.idle_after_out", g), 64'({in_ready, out_valid}), 64'(2'b10));
        idle_next = 0;
        if (out_valid) begin
          if (q.size() == 0) chk($sformatf("u%0d.spurious_out", g), 64'(out_valid), 64'(0));
          else begin
            if (!seen) chk($sformatf("u%0d.latency", g), 64'(cyc - q[0].t), 64'(L));
            seen = 1;
            chk($sformatf("u%0d.result", g), 64'({klass, mid}), 64'(q[0].r));
            chk($sformatf("u%0d.in_ready_done", g), 64'(in_ready), 64'(0));
            if (out_ready) begin
              void'(q.pop_front());
              seen = 0;
              idle_next = 1;
            end
          end
        end else if (q.size() > 0 && q[0].t < cyc) begin
          chk($sformatf("u%0d.busy", g), 64'(in_ready), 64'(0));
          if (cyc - q[0].t > L) begin
            chk($sformatf("u%0d.timeout", g), 64'(out_valid), 64'(1));
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    while (gi[1].ntx < 3 && cyc < LIMIT) begin
      @(posedge clk);
      #1;
    end
    while (cyc < gi[1].last_t + 3 && cyc < LIMIT) begin
      @(posedge clk);
      #1;
    end
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    while (!(gi[0].fin && gi[1].fin && gi[2].fin && gi[3].fin) && cyc < LIMIT) begin
      @(posedge clk);
      #1;
    end
    if (cyc >= LIMIT) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: still busy at cycle %0d, want all transactions done", cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
